keyenc_fifo: RTL and testbench

- Parametrised successor to the combinational 16-key priority encoder.
- Synchronises and debounces NKEYS raw key lines and priority-encodes the debounced state, lowest index wins.
- Turns each new key press into a press event and queues it in a small FIFO, drained by a valid/ready handshake.
- Sits between the keypad/switch inputs and the control logic that consumes key codes.

---
 rtl/keyenc_fifo.sv | 160 ++++++++++++++++
 tb/tb_keyenc_fifo.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keyenc_fifo.sv
`default_nettype none
// ============================================================================
// Module   : keyenc_fifo
// Purpose  : Synchronised, debounced key priority encoder feeding a press-event
//            FIFO. Optional auto-repeat is enabled by macro KEYENC_REPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module keyenc_fifo #(
    parameter int NKEYS      = 16,
    parameter int VW         = $clog2(NKEYS),
    parameter int DEB_CYCLES = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int REP_DELAY  = 500,
    parameter int REP_RATE   = 100
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NKEYS-1:0]              keys,
    output logic                          key_in,
    output logic [VW-1:0]                 key_val,
    output logic                          ev_valid,
    output logic [VW-1:0]                 ev_code,
    input  logic                          ev_ready,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count,
    output logic                          ovf,
    output logic                          lost,
    input  logic                          clr_flags
);

    localparam int c_cw = $clog2(DEB_CYCLES + 1);
    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_nw = c_aw + 1;
    localparam logic [c_cw-1:0] c_deb   = c_cw'(DEB_CYCLES);
    localparam logic [c_nw-1:0] c_depth = c_nw'(FIFO_DEPTH);

    function automatic logic [VW-1:0] lowest(input logic [NKEYS-1:0] v);
        lowest = '0;
        for (int i = NKEYS - 1; i >= 0; i--)
            if (v[i]) lowest = VW'(i);
    endfunction

    logic [NKEYS-1:0] r_s1, r_s2, r_db, r_db_d, w_db_next;
    logic [c_cw-1:0]  r_cnt [NKEYS];
    logic             r_key_in;
    logic [VW-1:0]    r_key_val;

    always_comb begin
        w_db_next = r_db;
        for (int i = 0; i < NKEYS; i++)
            if ((r_s2[i] != r_db[i]) && (r_cnt[i] == c_deb))
                w_db_next[i] = ~r_db[i];
    end

    // key_in/key_val load from the next debounced state so they move on the same edge as it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1      <= '0;
            r_s2      <= '0;
            r_db      <= '0;
            r_db_d    <= '0;
            r_key_in  <= 1'b0;
            r_key_val <= '0;
            for (int i = 0; i < NKEYS; i++) r_cnt[i] <= '0;
        end else begin
            r_s1      <= keys;
            r_s2      <= r_s1;
            r_db      <= w_db_next;
            r_db_d    <= r_db;
            r_key_in  <= |w_db_next;
            r_key_val <= lowest(w_db_next);
            for (int i = 0; i < NKEYS; i++) begin
                if ((r_s2[i] == r_db[i]) || (r_cnt[i] == c_deb))
                    r_cnt[i] <= '0;
                else
                    r_cnt[i] <= r_cnt[i] + 1'b1;
            end
        end
    end

    logic [NKEYS-1:0] w_rise;
    logic             w_press, w_multi, w_ev;
    logic [VW-1:0]    w_press_code, w_ev_code;

    assign w_rise       = r_db & ~r_db_d;
    assign w_press      = |w_rise;
    assign w_multi      = (w_rise & (w_rise - 1'b1)) != '0;
    assign w_press_code = lowest(w_rise);

`ifdef KEYENC_REPEAT_EN
    localparam int c_rw = $clog2(REP_DELAY + REP_RATE + 1);
    logic [c_rw-1:0] r_rep_cnt;
    logic            r_rep_first;
    logic            w_rep_hit, w_rep;

    assign w_rep_hit = r_rep_first ? (r_rep_cnt == c_rw'(REP_DELAY - 1))
                                   : (r_rep_cnt == c_rw'(REP_RATE - 1));
    assign w_rep     = w_rep_hit && (|r_db) && (r_db == r_db_d);

    // Any debounced change (including a press) restarts the delay phase
    always_ff @(posedge clk) begin
        if (!rst_n || (r_db != r_db_d) || !(|r_db)) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
        end else if (w_rep) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b0;
        end else begin
            r_rep_cnt   <= r_rep_cnt + 1'b1;
        end
    end

    assign w_ev      = w_press | w_rep;
    assign w_ev_code = w_press ? w_press_code : r_key_val;
`else
    assign w_ev      = w_press;
    assign w_ev_code = w_press_code;
`endif

    logic [VW-1:0]   r_mem [FIFO_DEPTH];
    logic [c_aw-1:0] r_wr, r_rd;
    logic [c_nw-1:0] r_count;
    logic            r_ovf, r_lost;
    logic            w_full, w_pop, w_push;

    assign w_full = (r_count == c_depth);
    assign w_pop  = (r_count != '0) && ev_ready;
    assign w_push = w_ev && (!w_full || w_pop);

    // Pointers wrap naturally because FIFO_DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_lost  <= 1'b0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
            r_ovf  <= (w_ev && w_full && !w_pop) || (r_ovf && !clr_flags);
            r_lost <= (w_press && w_multi)       || (r_lost && !clr_flags);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= w_ev_code;
    end

    assign key_in   = r_key_in;
    assign key_val  = r_key_val;
    assign ev_valid = (r_count != '0);
    assign ev_code  = ev_valid ? r_mem[r_rd] : '0;
    assign ev_count = r_count;
    assign ovf      = r_ovf;
    assign lost     = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_keyenc_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_keyenc_fifo
// Purpose  : Directed plus randomized self-checking bench for keyenc_fifo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keyenc_fifo;

    localparam int NKEYS = 16;
    localparam int VW    = 4;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NKEYS-1:0] keys;
    logic             key_in;
    logic [VW-1:0]    key_val;
    logic             ev_valid;
    logic [VW-1:0]    ev_code;
    logic             ev_ready;
    logic [2:0]       ev_count;
    logic             ovf;
    logic             lost;
    logic             clr_flags;

    int tests = 0;
    int fails = 0;

    keyenc_fifo #(.NKEYS(NKEYS), .DEB_CYCLES(4), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .keys(keys), .key_in(key_in), .key_val(key_val),
        .ev_valid(ev_valid), .ev_code(ev_code), .ev_ready(ev_ready),
        .ev_count(ev_count), .ovf(ovf), .lost(lost), .clr_flags(clr_flags)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Long enough for a press or release to debounce and its event to land
    task automatic settle();
        tick(12);
    endtask

    task automatic tap(input int k);
        keys[k] = 1'b1;
        settle();
        keys[k] = 1'b0;
        settle();
    endtask

    task automatic clear_flags();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
    endtask

    function automatic int low_idx(input logic [NKEYS-1:0] m);
        for (int i = 0; i < NKEYS; i++)
            if (m[i]) return i;
        return 0;
    endfunction

    int               q[$];
    logic             ovf_exp;
    logic [NKEYS-1:0] mask;
    int               n, k, guard;

    initial begin
        rst_n = 1'b0; keys = '0; ev_ready = 1'b0; clr_flags = 1'b0;
        tick(2);
        check("rst_key_in", key_in, 0);
        check("rst_key_val", key_val, 0);
        check("rst_ev_valid", ev_valid, 0);
        check("rst_ev_count", ev_count, 0);
        check("rst_ovf", ovf, 0);
        check("rst_lost", lost, 0);
        rst_n = 1'b1;
        tick(2);

        // Latency: raw key high before edge 0
        keys[5] = 1'b1;
        tick(6);
        check("lat_key_in_e5", key_in, 0);
        tick();
        check("lat_key_in_e6", key_in, 1);
        check("lat_key_val_e6", key_val, 5);
        check("lat_ev_valid_e6", ev_valid, 0);
        tick();
        check("lat_ev_valid_e7", ev_valid, 1);
        check("lat_ev_code_e7", ev_code, 5);
        check("lat_ev_count_e7", ev_count, 1);
        tick(3);
        check("hold_ev_code", ev_code, 5);
        keys[5] = 1'b0;
        settle();
        check("release_key_in", key_in, 0);
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        check("pop_single", ev_count, 0);
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        check("pop_empty_ignored", ev_count, 0);

        // Short glitch must not debounce
        keys[2] = 1'b1;
        tick(3);
        keys[2] = 1'b0;
        tick(10);
        check("glitch_key_in", key_in, 0);
        check("glitch_ev_count", ev_count, 0);

        // Simultaneous press: lowest wins, the other is lost
        keys[3] = 1'b1; keys[9] = 1'b1;
        settle();
        check("simul_key_val", key_val, 3);
        check("simul_lost", lost, 1);
        check("simul_ev_count", ev_count, 1);
        check("simul_ev_code", ev_code, 3);
        keys[3] = 1'b0;
        settle();
        check("rel3_key_val", key_val, 9);
        check("rel3_ev_count", ev_count, 1);
        keys[9] = 1'b0;
        settle();
        clear_flags();
        check("clr_lost", lost, 0);
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;

        // Overflow, then ordered drain
        tap(1); tap(4); tap(7); tap(10); tap(12);
        check("full_count", ev_count, 4);
        check("full_ovf", ovf, 1);
        ev_ready = 1'b1;
        foreach (q[i]) ;
        begin
            int exp_codes[4] = '{1, 4, 7, 10};
            for (int i = 0; i < 4; i++) begin
                check("drain_valid", ev_valid, 1);
                check("drain_code", ev_code, exp_codes[i]);
                tick();
            end
        end
        ev_ready = 1'b0;
        check("drain_empty", ev_valid, 0);
        clear_flags();
        check("clr_ovf", ovf, 0);

        // Full with simultaneous pop and push
        tap(1); tap(2); tap(3); tap(4);
        check("refill_count", ev_count, 4);
        keys[8] = 1'b1;
        tick(7);
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        check("pushpop_count", ev_count, 4);
        check("pushpop_ovf", ovf, 0);
        check("pushpop_head", ev_code, 2);
        keys[8] = 1'b0;
        settle();
        ev_ready = 1'b1;
        begin
            int exp_codes[4] = '{2, 3, 4, 8};
            for (int i = 0; i < 4; i++) begin
                check("pp_drain_code", ev_code, exp_codes[i]);
                tick();
            end
        end
        ev_ready = 1'b0;

        // Reset mid-operation
        keys[3] = 1'b1; keys[6] = 1'b1;
        settle();
        tap(11);
        rst_n = 1'b0;
        keys = '0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_key_in", key_in, 0);
        check("mid_rst_key_val", key_val, 0);
        check("mid_rst_ev_valid", ev_valid, 0);
        check("mid_rst_ev_code", ev_code, 0);
        check("mid_rst_ev_count", ev_count, 0);
        check("mid_rst_lost", lost, 0);
        check("mid_rst_ovf", ovf, 0);
        settle();

        // Randomized epochs: queue model of press events and drops
        for (int ep = 0; ep < 6; ep++) begin
            clear_flags();
            q.delete();
            ovf_exp = 1'b0;
            n = $urandom_range(6, 1);
            for (int j = 0; j < n; j++) begin
                k = $urandom_range(NKEYS - 1, 0);
                tap(k);
                if (q.size() < DEPTH) q.push_back(k);
                else ovf_exp = 1'b1;
            end
            check("rnd_count", ev_count, q.size());
            check("rnd_ovf", ovf, ovf_exp);
            guard = 0;
            while (q.size() > 0 && guard < 300) begin
                ev_ready = 1'($urandom_range(1, 0));
                check("rnd_valid", ev_valid, 1);
                if (ev_ready) begin
                    check("rnd_code", ev_code, q[0]);
                    void'(q.pop_front());
                end
                tick();
                guard++;
            end
            ev_ready = 1'b0;
            check("rnd_drain_timeout", q.size(), 0);
            check("rnd_empty", ev_valid, 0);
        end

        // Randomized simultaneous masks: priority and lost flag
        for (int ep = 0; ep < 6; ep++) begin
            clear_flags();
            mask = NKEYS'($urandom);
            if (mask == '0) mask[$urandom_range(NKEYS - 1, 0)] = 1'b1;
            keys = mask;
            settle();
            check("mask_key_in", key_in, 1);
            check("mask_key_val", key_val, low_idx(mask));
            check("mask_lost", lost, ($countones(mask) > 1));
            check("mask_count", ev_count, 1);
            check("mask_code", ev_code, low_idx(mask));
            keys = '0;
            settle();
            check("mask_rel_key_val", key_val, 0);
            ev_ready = 1'b1;
            tick();
            ev_ready = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
